// File: rtl/seq_pkg.sv
// State encoding and default pattern constants shared by the stream generator and the detectors.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int                     DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_hit_counter.sv
// Counts overlapping PATTERN matches over consumed bits, updated on the consume edge.
// Stalls with bit_en=0; clr restarts history so no match spans two frames.
module seq_hit_counter
  import seq_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int                HIST_W    = PAT_LEN - 1;
  localparam int                SEEN_W    = $clog2(PAT_LEN) + 1;
  localparam logic [SEEN_W-1:0] SEEN_FULL = SEEN_W'(PAT_LEN - 1);

  logic [HIST_W-1:0] history;
  logic [SEEN_W-1:0] seen;
  logic              match;

  // seen saturates once enough earlier bits exist to fill the history window
  assign match = bit_en && (seen == SEEN_FULL) && ({history, bit_in} == PATTERN);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      history <= '0;
      seen    <= '0;
      hit_cnt <= '0;
    end else if (bit_en) begin
      history <= HIST_W'({history, bit_in});
      if (seen != SEEN_FULL) seen <= seen + 1'b1;
      if (match && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_stream_gen.sv
// Serial frame transmitter: start accepted at edge k gives first bit at k+1, LSB first.
// en=0 stalls the stream with all outputs held; hit_cnt tracks PATTERN matches in the frame.
module seq_stream_gen
  import seq_pkg::*;
#(
  parameter int                 WIDTH   = 16,
  parameter int                 LEN_W   = 5,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  input  logic             en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] len_clamped;
  logic             accept;
  logic             consume;

  assign accept      = (state == IDLE) && start;
  assign consume     = (state == SHIFT) && en;
  assign len_clamped = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
  assign shreg_nxt   = shreg >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      remaining  <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= SHIFT;
              shreg      <= data;
              remaining  <= len_clamped;
              dout       <= data[0];
              dout_valid <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (en) begin
            if (remaining == LEN_W'(1)) begin
              state      <= DONE;
              dout       <= 1'b0;
              dout_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              shreg     <= shreg_nxt;
              dout      <= shreg_nxt[0];
              remaining <= remaining - 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // dout is the bit being consumed on a consume edge, so it feeds the matcher directly
  seq_hit_counter #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) u_hit (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .bit_in  (dout),
    .bit_en  (consume),
    .hit_cnt (hit_cnt)
  );

endmodule

// File: tb/tb_seq_stream_gen.sv
// Scoreboard bench for seq_stream_gen: frames are modelled as bit lists, monitor checks every consume and done.
module tb_seq_stream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data;
  logic [4:0]  len;
  logic        en;
  logic        dout;
  logic        dout_valid;
  logic        busy;
  logic        done;
  logic [7:0]  hit_cnt;

  seq_stream_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data       (data),
    .len        (len),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done),
    .hit_cnt    (hit_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int hits;
    int cyc;
  } done_rec_t;

  bit        exp_bits[$];
  done_rec_t exp_done[$];
  done_rec_t rec;
  int        idle_hits = 0;
  int        n_chk = 0;
  int        n_fail = 0;

  localparam logic [3:0] PAT = 4'b1101;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one scoreboard pop per consumed bit and per done pulse
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_eq_valid", 32'(busy), 32'(dout_valid));
      if (!dout_valid) check("dout_zero_when_invalid", 32'(dout), 32'd0);
      if (dout_valid && en) begin
        if (exp_bits.size() == 0) check("unexpected_bit", 32'(dout_valid), 32'd0);
        else check("dout_bit", 32'(dout), 32'(exp_bits.pop_front()));
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          rec = exp_done.pop_front();
          check("done_cycle", 32'(cyc), 32'(rec.cyc));
          check("hit_cnt_at_done", 32'(hit_cnt), 32'(rec.hits));
          check("bits_left_at_done", 32'(exp_bits.size()), 32'd0);
          idle_hits = rec.hits;
        end
      end else if (!busy) begin
        check("hit_cnt_hold", 32'(hit_cnt), 32'(idle_hits));
      end
    end
  end

  // Called and returns at 2 time units after a rising edge. mode: 0 en high, 1 toggle, 2 random.
  task automatic run_frame(input logic [15:0] d, input logic [4:0] l, input int mode, input bit junk);
    bit bits[$];
    bit en_seq[$];
    int L;
    int hits;
    int consumed;
    int j;
    int k;
    bit e;
    L = (l > 5'd16) ? 16 : int'(l);
    for (int i = 0; i < L; i++) bits.push_back(d[i]);
    hits = 0;
    for (int i = 3; i < L; i++)
      if ({bits[i-3], bits[i-2], bits[i-1], bits[i]} == PAT) hits++;
    consumed = 0;
    j = 0;
    while (consumed < L) begin
      j++;
      case (mode)
        0:       e = 1'b1;
        1:       e = (j % 2 == 1);
        default: e = ($urandom_range(0, 2) != 0);
      endcase
      en_seq.push_back(e);
      if (e) consumed++;
    end
    k = cyc + 1;
    start = 1'b1;
    data  = d;
    len   = l;
    en    = 1'($urandom_range(0, 1));
    foreach (bits[i]) exp_bits.push_back(bits[i]);
    exp_done.push_back('{hits, k + j});
    @(posedge clk); #2;
    foreach (en_seq[i]) begin
      start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      data  = 16'($urandom);
      len   = 5'($urandom_range(1, 31));
      en    = en_seq[i];
      @(posedge clk); #2;
    end
    start = junk;
    data  = 16'($urandom);
    len   = 5'($urandom_range(1, 31));
    en    = 1'($urandom_range(0, 1));
    @(posedge clk); #2;
    start = 1'b0;
    en    = 1'b0;
  endtask

  task automatic reset_mid_frame();
    start = 1'b1;
    data  = 16'h06DD;
    len   = 5'd11;
    en    = 1'b1;
    for (int i = 0; i < 11; i++) exp_bits.push_back(data[i]);
    exp_done.push_back('{2, cyc + 12});
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #2;
    end
    check("fifth_bit_before_reset", 32'(dout), 32'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    en  = 1'b0;
    exp_bits.delete();
    exp_done.delete();
    idle_hits = 0;
    check("rst_mid_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_hit_cnt", 32'(hit_cnt), 32'd0);
    repeat (3) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    en    = 1'b0;
    data  = '0;
    len   = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_dout_valid", 32'(dout_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hit_cnt", 32'(hit_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    run_frame(16'h06DD, 5'd11, 0, 1'b0);
    run_frame(16'h06DD, 5'd11, 1, 1'b0);
    run_frame(16'($urandom), 5'd0, 0, 1'b1);
    run_frame(16'($urandom), 5'd20, 0, 1'b0);
    run_frame(16'hDDDD, 5'd16, 0, 1'b1);
    reset_mid_frame();
    run_frame(16'h06DD, 5'd11, 0, 1'b0);
    run_frame(16'hFFFF, 5'd31, 2, 1'b1);

    for (int n = 0; n < 30; n++) begin
      run_frame(16'($urandom), 5'($urandom_range(0, 31)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #2;
      end
    end

    repeat (5) @(posedge clk);
    #2;
    check("exp_bits_drained", 32'(exp_bits.size()), 32'd0);
    check("exp_done_drained", 32'(exp_done.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
